// File: rtl/uncached_write_buffer_pkg.sv
// Shared types and constants for the uncached write buffer.
//   wbuf_entry_t : one posted store (address, size, strobes, data, valid)
//   wbuf_state_t : AXI issue FSM states
//   BURST_INCR / LEN_SINGLE : fixed AXI burst encodings for single-beat writes
//   word_match   : true when two byte addresses fall in the same 32-bit word
package uncached_write_buffer_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        valid;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StResp
  } wbuf_state_t;

  function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

endpackage

// File: rtl/uncached_write_buffer.sv
// Posted-write FIFO between the DCache uncached-store path and an AXI write port.
// Stores are accepted on req_*, issued in order as single-beat AXI writes on AW/W,
// and each entry is held until its B response so chk_conflict can stall younger
// uncached loads to the same word.
//   req_*        : store push interface (req_ready = not full)
//   chk_addr/chk_conflict : combinational word-address match against resident entries
//   empty        : no resident entries (fence/SYNC drain)
//   aw*/w*/b*    : AXI4 write address, data and response channels
module uncached_write_buffer
  import uncached_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter logic [3:0]  AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  input  logic [31:0] chk_addr,
  output logic        chk_conflict,
  output logic        empty,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  wbuf_entry_t     mem_q [DEPTH];
  wbuf_entry_t     head_entry;
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  wbuf_state_t     state_q;
  logic            aw_done_q, w_done_q;
  logic            awvalid_q, wvalid_q, bready_q;
  logic            aw_hs, w_hs, aw_fin, w_fin;

  // Full-ness uses registered count only: a pop in the same cycle does not free a slot.
  assign req_ready = (count_q != CntFull);
  assign push      = req_valid && req_ready;
  assign pop       = bvalid && bready_q;
  assign empty     = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i].valid <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[tail_q] <= '{addr: req_addr, size: req_size, wstrb: req_wstrb,
                           wdata: req_wdata, valid: 1'b1};
        tail_q        <= tail_q + PtrW'(1);
      end
      if (pop) begin
        mem_q[head_q].valid <= 1'b0;
        head_q              <= head_q + PtrW'(1);
      end
    end
  end

  // The in-flight head stays valid until B, so it is covered by this match.
  always_comb begin
    chk_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid && word_match(mem_q[i].addr, chk_addr)) begin
        chk_conflict = 1'b1;
      end
    end
  end

  assign aw_hs  = awvalid_q && awready;
  assign w_hs   = wvalid_q && wready;
  assign aw_fin = aw_done_q || aw_hs;
  assign w_fin  = w_done_q || w_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            state_q   <= StSend;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
          end
        end
        StSend: begin
          if (aw_fin && w_fin) begin
            state_q   <= StResp;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b1;
          end else begin
            if (aw_hs) begin
              aw_done_q <= 1'b1;
              awvalid_q <= 1'b0;
            end
            if (w_hs) begin
              w_done_q <= 1'b1;
              wvalid_q <= 1'b0;
            end
          end
        end
        StResp: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            // count_d already accounts for the pop and any same-cycle push.
            if (count_d != '0) begin
              state_q   <= StSend;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign head_entry = mem_q[head_q];

  assign awid    = AXI_ID;
  assign awaddr  = head_entry.addr;
  assign awlen   = LEN_SINGLE;
  assign awsize  = {1'b0, head_entry.size};
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign awvalid = awvalid_q;
  assign wid     = AXI_ID;
  assign wdata   = head_entry.wdata;
  assign wstrb   = head_entry.wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  // B response contents and the byte offset of the check address are not needed.
  logic unused_inputs;
  assign unused_inputs = ^{bid, bresp, chk_addr[1:0], head_entry.valid};

endmodule

// File: tb/tb_uncached_write_buffer.sv
module tb_uncached_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic [31:0] chk_addr;
  logic        chk_conflict;
  logic        empty;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uncached_write_buffer #(.DEPTH(4), .AXI_ID(4'd1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .chk_addr(chk_addr), .chk_conflict(chk_conflict), .empty(empty),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; the store is sampled on the following posedge.
  task automatic push(input logic [31:0] a, input logic [1:0] s, input logic [3:0] st,
                      input logic [31:0] d);
    req_valid = 1'b1; req_addr = a; req_size = s; req_wstrb = st; req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic bpulse();
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
  endtask

  task automatic wait_awvalid(input string name);
    int n = 0;
    while (!awvalid && n < 40) begin tick(); n++; end
    checks++;
    if (awvalid !== 1'b1) begin
      errors++; $display("FAIL %s awvalid timeout: got %b want 1", name, awvalid);
    end
  endtask

  task automatic wait_bready(input string name);
    int n = 0;
    while (!bready && n < 40) begin tick(); n++; end
    checks++;
    if (bready !== 1'b1) begin
      errors++; $display("FAIL %s bready timeout: got %b want 1", name, bready);
    end
  endtask

  // Needs awready/wready high; checks the head presented on AW/W, then returns B.
  task automatic serve_one(input string name, input logic [31:0] ea, input logic [2:0] esz,
                           input logic [3:0] es, input logic [31:0] ed);
    wait_awvalid(name);
    checks++;
    if (awaddr !== ea) begin
      errors++; $display("FAIL %s awaddr: got %h want %h", name, awaddr, ea);
    end
    checks++;
    if (awsize !== esz) begin
      errors++; $display("FAIL %s awsize: got %0d want %0d", name, awsize, esz);
    end
    checks++;
    if (wstrb !== es) begin
      errors++; $display("FAIL %s wstrb: got %h want %h", name, wstrb, es);
    end
    checks++;
    if (wdata !== ed) begin
      errors++; $display("FAIL %s wdata: got %h want %h", name, wdata, ed);
    end
    wait_bready(name);
    bpulse();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0; req_wstrb = '0;
    req_wdata = '0; chk_addr = '0; awready = 1'b0; wready = 1'b0; bid = '0;
    bresp = '0; bvalid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset empty: got %b want 1", empty); end
    checks++; if (chk_conflict !== 1'b0) begin errors++; $display("FAIL reset chk_conflict: got %b want 0", chk_conflict); end
    checks++; if ({awvalid, wvalid, bready} !== 3'b000) begin errors++; $display("FAIL reset valids: got %b want 000", {awvalid, wvalid, bready}); end
    checks++; if (awlen !== 8'd0 || awburst !== 2'b01 || wlast !== 1'b1) begin errors++; $display("FAIL reset consts: got len=%h burst=%b last=%b want 00 01 1", awlen, awburst, wlast); end
    checks++; if (awid !== 4'd1 || wid !== 4'd1) begin errors++; $display("FAIL reset ids: got %h %h want 1 1", awid, wid); end
    checks++; if ({awlock, awcache, awprot} !== 9'd0) begin errors++; $display("FAIL reset attrs: got %h want 0", {awlock, awcache, awprot}); end
  endtask

  task automatic test_single();
    awready = 1'b1; wready = 1'b1;
    push(32'h1FAF_F000, 2'd2, 4'hF, 32'hDEAD_BEEF);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single empty after push: got %b want 0", empty); end
    wait_awvalid("single");
    checks++; if (awaddr !== 32'h1FAF_F000) begin errors++; $display("FAIL single awaddr: got %h want 1faff000", awaddr); end
    checks++; if (awsize !== 3'd2) begin errors++; $display("FAIL single awsize: got %0d want 2", awsize); end
    checks++; if (wlast !== 1'b1 || wvalid !== 1'b1) begin errors++; $display("FAIL single wlast/wvalid: got %b%b want 11", wlast, wvalid); end
    checks++; if (wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin errors++; $display("FAIL single wdata: got %h/%h want deadbeef/f", wdata, wstrb); end
    wait_bready("single");
    checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0) begin errors++; $display("FAIL single valids in resp: got %b%b want 00", awvalid, wvalid); end
    tick();
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single empty before b: got %b want 0", empty); end
    bpulse();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single empty after b: got %b want 1", empty); end
    checks++; if (bready !== 1'b0) begin errors++; $display("FAIL single bready after b: got %b want 0", bready); end
  endtask

  task automatic test_fill();
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(32'h0000_1000 + 32'(i * 4), 2'd2, 4'hF, 32'hA000_0000 + 32'(i));
    end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill req_ready full: got %b want 0", req_ready); end
    req_valid = 1'b1; req_addr = 32'h0000_5555; req_wdata = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL fill held off %0d: got %b want 0", i, req_ready); end
    end
    req_valid = 1'b0;
    awready = 1'b1; wready = 1'b1;
    serve_one("fill0", 32'h0000_1000, 3'd2, 4'hF, 32'hA000_0000);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill req_ready after pop: got %b want 1", req_ready); end
    for (int i = 1; i < 4; i++) begin
      serve_one("fill", 32'h0000_1000 + 32'(i * 4), 3'd2, 4'hF, 32'hA000_0000 + 32'(i));
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill drained empty: got %b want 1", empty); end
  endtask

  task automatic test_ordering();
    // W completes first.
    awready = 1'b0; wready = 1'b0;
    push(32'h2000_0040, 2'd1, 4'b0011, 32'h0000_BEEF);
    wait_awvalid("wfirst");
    wready = 1'b1; tick(); wready = 1'b0;
    checks++; if ({awvalid, wvalid} !== 2'b10) begin errors++; $display("FAIL wfirst aw/w: got %b want 10", {awvalid, wvalid}); end
    tick(); tick();
    checks++; if ({awvalid, wvalid, bready} !== 3'b100) begin errors++; $display("FAIL wfirst wait: got %b want 100", {awvalid, wvalid, bready}); end
    checks++; if (awsize !== 3'd1) begin errors++; $display("FAIL wfirst awsize: got %0d want 1", awsize); end
    awready = 1'b1; tick(); awready = 1'b0;
    checks++; if ({awvalid, bready} !== 2'b01) begin errors++; $display("FAIL wfirst resp: got %b want 01", {awvalid, bready}); end
    bpulse();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wfirst empty: got %b want 1", empty); end
    // AW completes first.
    push(32'h2000_0080, 2'd2, 4'hF, 32'h1234_5678);
    wait_awvalid("awfirst");
    awready = 1'b1; tick(); awready = 1'b0;
    checks++; if ({awvalid, wvalid} !== 2'b01) begin errors++; $display("FAIL awfirst aw/w: got %b want 01", {awvalid, wvalid}); end
    tick(); tick();
    checks++; if ({awvalid, wvalid, bready} !== 3'b010) begin errors++; $display("FAIL awfirst wait: got %b want 010", {awvalid, wvalid, bready}); end
    wready = 1'b1; tick(); wready = 1'b0;
    checks++; if ({wvalid, bready} !== 2'b01) begin errors++; $display("FAIL awfirst resp: got %b want 01", {wvalid, bready}); end
    bpulse();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL awfirst empty: got %b want 1", empty); end
  endtask

  task automatic test_conflict();
    awready = 1'b0; wready = 1'b0;
    chk_addr = 32'hBFD0_0010;
    req_valid = 1'b1; req_addr = 32'hBFD0_0010; req_size = 2'd2; req_wstrb = 4'hF;
    req_wdata = 32'h0000_0010;
    #1;
    checks++; if (chk_conflict !== 1'b0) begin errors++; $display("FAIL conflict same-cycle push: got %b want 0", chk_conflict); end
    tick(); req_valid = 1'b0;
    checks++; if (chk_conflict !== 1'b1) begin errors++; $display("FAIL conflict after push: got %b want 1", chk_conflict); end
    push(32'hBFD0_0020, 2'd2, 4'hF, 32'h0000_0020);
    chk_addr = 32'hBFD0_0012; #1;
    checks++; if (chk_conflict !== 1'b1) begin errors++; $display("FAIL conflict 0012: got %b want 1", chk_conflict); end
    chk_addr = 32'hBFD0_0014; #1;
    checks++; if (chk_conflict !== 1'b0) begin errors++; $display("FAIL conflict 0014: got %b want 0", chk_conflict); end
    chk_addr = 32'hBFD0_0023; #1;
    checks++; if (chk_conflict !== 1'b1) begin errors++; $display("FAIL conflict 0023: got %b want 1", chk_conflict); end
    tick();
    awready = 1'b1; wready = 1'b1;
    serve_one("conf0", 32'hBFD0_0010, 3'd2, 4'hF, 32'h0000_0010);
    chk_addr = 32'hBFD0_0012; #1;
    checks++; if (chk_conflict !== 1'b0) begin errors++; $display("FAIL conflict 0012 popped: got %b want 0", chk_conflict); end
    chk_addr = 32'hBFD0_0020; #1;
    checks++; if (chk_conflict !== 1'b1) begin errors++; $display("FAIL conflict 0020 resident: got %b want 1", chk_conflict); end
    serve_one("conf1", 32'hBFD0_0020, 3'd2, 4'hF, 32'h0000_0020);
    checks++; if (chk_conflict !== 1'b0) begin errors++; $display("FAIL conflict 0020 popped: got %b want 0", chk_conflict); end
  endtask

  task automatic test_simultaneous();
    reset = 1'b1; tick(); reset = 1'b0;
    awready = 1'b1; wready = 1'b1;
    push(32'h3000_0000, 2'd2, 4'hF, 32'h0000_000A);
    push(32'h3000_0004, 2'd2, 4'hF, 32'h0000_000B);
    push(32'h3000_0008, 2'd2, 4'hF, 32'h0000_000C);
    wait_bready("simA");
    // count 3: pop A while pushing D into slot 3.
    req_valid = 1'b1; req_addr = 32'h3000_000C; req_size = 2'd1; req_wstrb = 4'b1100;
    req_wdata = 32'h0000_000D; bvalid = 1'b1;
    tick();
    req_valid = 1'b0; bvalid = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL simul1 req_ready: got %b want 1", req_ready); end
    wait_bready("simB");
    // pop B while pushing E into wrapped slot 0; stall AW/W so C waits.
    awready = 1'b0; wready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h3000_0010; req_size = 2'd0; req_wstrb = 4'b0001;
    req_wdata = 32'h0000_000E; bvalid = 1'b1;
    tick();
    req_valid = 1'b0; bvalid = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL simul2 req_ready: got %b want 1", req_ready); end
    push(32'h3000_0014, 2'd2, 4'hF, 32'h0000_000F);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL simul count4 req_ready: got %b want 0", req_ready); end
    awready = 1'b1; wready = 1'b1;
    serve_one("simC", 32'h3000_0008, 3'd2, 4'hF, 32'h0000_000C);
    serve_one("simD", 32'h3000_000C, 3'd1, 4'b1100, 32'h0000_000D);
    serve_one("simE", 32'h3000_0010, 3'd0, 4'b0001, 32'h0000_000E);
    serve_one("simF", 32'h3000_0014, 3'd2, 4'hF, 32'h0000_000F);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul empty: got %b want 1", empty); end
  endtask

  task automatic test_reset_mid();
    awready = 1'b1; wready = 1'b1;
    push(32'h4000_0000, 2'd2, 4'hF, 32'h0000_0001);
    push(32'h4000_0004, 2'd2, 4'hF, 32'h0000_0002);
    wait_bready("rstmid");
    reset = 1'b1;
    tick();
    checks++; if (empty !== 1'b1 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid empty/ready: got %b%b want 11", empty, req_ready); end
    checks++; if ({awvalid, wvalid, bready} !== 3'b000) begin errors++; $display("FAIL rstmid valids: got %b want 000", {awvalid, wvalid, bready}); end
    chk_addr = 32'h4000_0004; #1;
    checks++; if (chk_conflict !== 1'b0) begin errors++; $display("FAIL rstmid chk_conflict: got %b want 0", chk_conflict); end
    reset = 1'b0;
    push(32'h4000_0100, 2'd2, 4'hF, 32'h0000_600D);
    serve_one("rstmid_new", 32'h4000_0100, 3'd2, 4'hF, 32'h0000_600D);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rstmid empty end: got %b want 1", empty); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_ordering();
    test_conflict();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uncached_write_buffer.md
Name: uncached_write_buffer

Overview:
- Posted-write FIFO between the DCache uncached-store path and the AXI write channel.
- Accepts single-beat uncached stores, retires them in order as AXI4 single-beat writes (AW, W, B).
- Each entry stays resident until its B response arrives.
- Provides a combinational address-conflict check so uncached loads stall behind older pending stores to the same word.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, >= 2
- AXI_ID, 4'd1, constant ID driven on awid/wid

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  store request from DCache uncached path
- req_ready  out  1  buffer can accept (not full)
- req_addr  in  32  physical byte address
- req_size  in  2  0=byte, 1=half, 2=word
- req_wstrb  in  4  byte strobes
- req_wdata  in  32  store data
- chk_addr  in  32  physical address of pending uncached load
- chk_conflict  out  1  some resident entry matches chk_addr[31:2]
- empty  out  1  no resident entries (used by SYNC/fence drain)
- awid  out  4  = AXI_ID
- awaddr  out  32  head entry address
- awlen  out  8  constant 0
- awsize  out  3  {1'b0, head size}
- awburst  out  2  constant 2'b01
- awlock  out  2  constant 0
- awcache  out  4  constant 0
- awprot  out  3  constant 0
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- wid  out  4  = AXI_ID
- wdata  out  32  head entry data
- wstrb  out  4  head entry strobes
- wlast  out  1  constant 1
- wvalid  out  1  W valid
- wready  in  1  W ready
- bid  in  4  ignored
- bresp  in  2  ignored; no error reporting
- bvalid  in  1  B valid
- bready  out  1  B ready

Behaviour:
- Storage: DEPTH entries {addr, size, wstrb, wdata, valid}; head/tail pointers $clog2(DEPTH) bits, natural wrap; count $clog2(DEPTH)+1 bits.
- Push: req_valid && req_ready writes the tail entry next cycle; req_ready = (count != DEPTH). It depends only on registered state, never on bvalid, so there is no push while full even if a pop occurs that cycle.
- Pop: the head entry is freed on the cycle bvalid && bready. Simultaneous push and pop leaves count unchanged.
- chk_conflict: combinational OR over all valid entries of (entry.addr[31:2] == chk_addr[31:2]). It includes the in-flight head, and an entry pushed this cycle is not yet visible. chk_conflict = 0 when empty.
- empty = (count == 0). A push makes it fall on the next cycle; it rises on the cycle after the last pop.
- FSM states:
  - IDLE: awvalid = wvalid = bready = 0. Go to SEND when count != 0.
  - SEND: awvalid = !aw_done, wvalid = !w_done. aw_done sets on awready && awvalid; w_done sets on wready && wvalid. The two channels complete independently and in either order. When both are done (including the same cycle), clear both flags and go to RESP.
  - RESP: bready = 1. On bvalid, pop; go to SEND if count after pop != 0, else IDLE. There is no idle bubble between back-to-back entries other than the RESP-to-SEND transition cycle.
- awaddr, awsize, wdata and wstrb come from the head entry and are held stable while valid is high (AXI rule).
- Reset (synchronous, any state, including mid-transaction):
  - head = tail = count = 0, FSM = IDLE, aw_done = w_done = 0, all entry valids cleared.
  - Outputs after reset: req_ready = 1, empty = 1, chk_conflict = 0, awvalid = wvalid = bready = 0.
  - A transaction in flight at reset is abandoned. The system reset also resets the interconnect.

Decomposition:
- Shared package, in cpu_defs.svh:
  - wbuf_entry_t typedef: addr, size, wstrb, wdata, valid.
  - wbuf_state_t enum: IDLE/SEND/RESP.
  - AXI constants: BURST_INCR, LEN_SINGLE.
- No sub-module; the FIFO and FSM are small enough to be inline. Optionally split out an address-match comparator as wbuf_match, a pure combinational helper.

Test Plan:
- Single store 0x1FAF_F000, wstrb 4'hF, data 0xDEADBEEF; awready/wready held at 1, bvalid 2 cycles after W:
  - awaddr = 0x1FAFF000, awsize = 3'd2, wlast = 1.
  - empty returns to 1 on the cycle after the bvalid pop.
- Fill DEPTH=4 with AXI stalled (awready = 0):
  - req_ready drops after the 4th push; a 5th req_valid is held off.
  - Releasing the stall drains the entries in push order; req_ready rises the cycle after the first pop.
- Channel ordering:
  - wready 3 cycles before awready: W completes first, wvalid drops, awvalid stays.
  - The RESP state is entered only after AW completes. Repeat with AW first.
- Conflict check: entries at 0xBFD0_0010 and 0xBFD0_0020:
  - chk_addr 0xBFD00012 gives chk_conflict = 1; 0xBFD00014 gives 0.
  - After 0x...10 is popped, 0xBFD00012 gives 0.
- Same-cycle push and pop at count = 3: count stays 3 and the new entry lands at the wrapped tail (pointer 3 then 0), in order.
- Reset asserted in RESP with 2 entries:
  - Next cycle: empty = 1, bready = 0, awvalid = 0, req_ready = 1.
  - A subsequent push issues from entry 0.
